// File: rtl/irq_aggregator_pkg.sv
// Shared constants and helpers for the interrupt aggregator: register map,
// STATUS layout and the id-width function.
package irq_aggregator_pkg;

   localparam logic [1:0] REG_ENABLE  = 2'd0;
   localparam logic [1:0] REG_PENDING = 2'd1;
   localparam logic [1:0] REG_MODE    = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   localparam int STATUS_IRQ_BIT = 31;

   // Bits needed to name any channel; a single channel still gets a 1-bit id.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 6; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/irq_aggregator_if.sv
// CPU-side port of the interrupt aggregator: request/acknowledge handshake plus
// the small register read/write port.
interface irq_aggregator_if
   import irq_aggregator_pkg::*;
#(
   parameter int IDW = clog2_min1(8)
);
   logic           irq;
   logic [IDW-1:0] irq_id;
   logic           ack;
   logic [IDW-1:0] ack_id;
   logic [1:0]     reg_addr;
   logic [31:0]    reg_d;
   logic           reg_we;
   logic [31:0]    reg_q;

   modport master (
      input  irq, irq_id, reg_q,
      output ack, ack_id, reg_addr, reg_d, reg_we
   );

   modport slave (
      output irq, irq_id, reg_q,
      input  ack, ack_id, reg_addr, reg_d, reg_we
   );
endinterface

// File: rtl/irq_aggregator_sync.sv
// One-bit multi-flop synchroniser that brings an asynchronous interrupt level
// into the clk domain.
module irq_sync
   import irq_aggregator_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic nreset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) sync_q <= '0;
      else         sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/irq_aggregator.sv
// Collects CHANNELS asynchronous interrupt sources into one lowest-index-wins
// request. Optional per-channel level sensitivity via IRQ_AGGREGATOR_LEVEL_MODE_EN.
module irq_aggregator
   import irq_aggregator_pkg::*;
#(
   parameter int                  CHANNELS     = 8,
   parameter int                  SYNC_STAGES  = 2,
   parameter logic [CHANNELS-1:0] ENABLE_RESET = '0
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic [CHANNELS-1:0] irq_in,
   irq_aggregator_if.slave     bus
);

   localparam int IDW = clog2_min1(CHANNELS);

   logic [CHANNELS-1:0] sync_lvl;
   logic [CHANNELS-1:0] prev_q, prev_d;
   logic [CHANNELS-1:0] edge_det;
   logic [CHANNELS-1:0] pending_q, pending_d;
   logic [CHANNELS-1:0] enable_q, enable_d;
   logic [CHANNELS-1:0] active;
   logic [CHANNELS-1:0] ack_clr;
   logic [CHANNELS-1:0] w1c_clr;
   logic [CHANNELS-1:0] level_ch;
   logic [CHANNELS-1:0] mode_rd;
   logic                irq_q, irq_d;
   logic [IDW-1:0]      irq_id_q, irq_id_d;
   logic [31:0]         rdata_q, rdata_d;

   function automatic logic [IDW-1:0] lowest_index(input logic [CHANNELS-1:0] v);
      logic [IDW-1:0] idx;
      idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (v[i]) idx = IDW'(i);
      end
      return idx;
   endfunction

   for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
      irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk    (clk),
         .nreset (nreset),
         .d      (irq_in[g]),
         .q      (sync_lvl[g])
      );
   end

`ifdef IRQ_AGGREGATOR_LEVEL_MODE_EN
   logic [CHANNELS-1:0] mode_q, mode_d;

   always_comb begin
      mode_d = mode_q;
      if (bus.reg_we && bus.reg_addr == REG_MODE) mode_d = bus.reg_d[CHANNELS-1:0];
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) mode_q <= '0;
      else         mode_q <= mode_d;
   end

   assign level_ch = mode_q;
   assign mode_rd  = mode_q;
`else
   assign level_ch = '0;
   assign mode_rd  = '0;
`endif

   // An edge outranks both clear sources so an event arriving during a clear survives.
   always_comb begin
      prev_d   = sync_lvl;
      edge_det = sync_lvl & ~prev_q;

      ack_clr = '0;
      if (bus.ack && (int'(bus.ack_id) < CHANNELS)) ack_clr[bus.ack_id] = 1'b1;

      w1c_clr = '0;
      if (bus.reg_we && bus.reg_addr == REG_PENDING) w1c_clr = bus.reg_d[CHANNELS-1:0];

      pending_d = (level_ch & sync_lvl)
                | (~level_ch & (edge_det | (pending_q & ~ack_clr & ~w1c_clr)));

      enable_d = enable_q;
      if (bus.reg_we && bus.reg_addr == REG_ENABLE) enable_d = bus.reg_d[CHANNELS-1:0];

      active   = pending_q & enable_q;
      irq_d    = |active;
      irq_id_d = lowest_index(active);
   end

   always_comb begin
      rdata_d = '0;
      case (bus.reg_addr)
         REG_ENABLE:  rdata_d[CHANNELS-1:0] = enable_q;
         REG_PENDING: rdata_d[CHANNELS-1:0] = pending_q;
         REG_MODE:    rdata_d[CHANNELS-1:0] = mode_rd;
         default: begin
            rdata_d[STATUS_IRQ_BIT] = irq_q;
            rdata_d[IDW-1:0]        = irq_id_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         prev_q    <= '0;
         pending_q <= '0;
         enable_q  <= ENABLE_RESET;
         irq_q     <= 1'b0;
         irq_id_q  <= '0;
         rdata_q   <= '0;
      end else begin
         prev_q    <= prev_d;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         irq_q     <= irq_d;
         irq_id_q  <= irq_id_d;
         rdata_q   <= rdata_d;
      end
   end

   assign bus.irq    = irq_q;
   assign bus.irq_id = irq_id_q;
   assign bus.reg_q  = rdata_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed bench for irq_aggregator: a table of steady-state register/ack
// vectors followed by hand-written cycle-exact sequences.
module tb_irq_aggregator;
   import irq_aggregator_pkg::*;

   localparam logic [31:0] MODE_EXP =
`ifdef IRQ_AGGREGATOR_LEVEL_MODE_EN
      32'h1;
`else
      32'h0;
`endif

   typedef struct {
      string       name;
      logic [7:0]  irqIn;
      logic        doWrite;
      logic [1:0]  addr;
      logic [31:0] data;
      logic        doAck;
      logic [2:0]  ackId;
      logic [1:0]  rdAddr;
      logic        expIrq;
      logic [2:0]  expId;
      logic [31:0] expRd;
   } vec_t;

   logic       clk;
   logic       nreset;
   logic [7:0] irqIn;
   int         checks;
   int         failures;
   vec_t       vecs[21];

   irq_aggregator_if #(.IDW(3)) bus ();

   irq_aggregator dut (
      .clk    (clk),
      .nreset (nreset),
      .irq_in (irqIn),
      .bus    (bus)
   );

   // Free-running clock; inputs change and outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input string n, input logic [7:0] ii, input logic w,
                               input logic [1:0] a, input logic [31:0] d, input logic k,
                               input logic [2:0] kid, input logic [1:0] ra,
                               input logic ei, input logic [2:0] eid, input logic [31:0] er);
      vec_t v;
      v.name = n; v.irqIn = ii; v.doWrite = w; v.addr = a; v.data = d;
      v.doAck = k; v.ackId = kid; v.rdAddr = ra;
      v.expIrq = ei; v.expId = eid; v.expRd = er;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic regWrite(input logic [1:0] a, input logic [31:0] d);
      bus.reg_addr = a;
      bus.reg_d    = d;
      bus.reg_we   = 1'b1;
      step(1);
      bus.reg_we   = 1'b0;
   endtask

   task automatic ackPulse(input logic [2:0] id);
      bus.ack    = 1'b1;
      bus.ack_id = id;
      step(1);
      bus.ack    = 1'b0;
   endtask

   // One table row: drive sources, optional write and ack, settle, then read back.
   task automatic applyStimulus(input vec_t v);
      irqIn = v.irqIn;
      if (v.doWrite) regWrite(v.addr, v.data);
      if (v.doAck) ackPulse(v.ackId);
      step(6);
      bus.reg_addr = v.rdAddr;
      step(1);
      checkOutput({v.name, "_irq"}, 32'(bus.irq), 32'(v.expIrq));
      checkOutput({v.name, "_id"}, 32'(bus.irq_id), 32'(v.expId));
      checkOutput({v.name, "_rd"}, bus.reg_q, v.expRd);
   endtask

   initial begin
      checks = 0; failures = 0;
      nreset = 1'b0; irqIn = '0;
      bus.ack = 1'b0; bus.ack_id = '0; bus.reg_addr = REG_ENABLE;
      bus.reg_d = '0; bus.reg_we = 1'b0;

      vecs[0]  = mk("enable_all",  8'h00, 1, REG_ENABLE,  32'hFF,       0, 0, REG_ENABLE,  0, 0, 32'hFF);
      vecs[1]  = mk("ch5_edge",    8'h20, 0, REG_ENABLE,  0,            0, 0, REG_PENDING, 1, 5, 32'h20);
      vecs[2]  = mk("ch5_release", 8'h00, 0, REG_ENABLE,  0,            0, 0, REG_PENDING, 1, 5, 32'h20);
      vecs[3]  = mk("ack5",        8'h00, 0, REG_ENABLE,  0,            1, 5, REG_PENDING, 0, 0, 32'h00);
      vecs[4]  = mk("ch2_ch6",     8'h44, 0, REG_ENABLE,  0,            0, 0, REG_PENDING, 1, 2, 32'h44);
      vecs[5]  = mk("ack2",        8'h00, 0, REG_ENABLE,  0,            1, 2, REG_PENDING, 1, 6, 32'h40);
      vecs[6]  = mk("ack6",        8'h00, 0, REG_ENABLE,  0,            1, 6, REG_PENDING, 0, 0, 32'h00);
      vecs[7]  = mk("disable_all", 8'h00, 1, REG_ENABLE,  32'h00,       0, 0, REG_ENABLE,  0, 0, 32'h00);
      vecs[8]  = mk("ch1_masked",  8'h02, 0, REG_ENABLE,  0,            0, 0, REG_PENDING, 0, 0, 32'h02);
      vecs[9]  = mk("enable_ch1",  8'h00, 1, REG_ENABLE,  32'h02,       0, 0, REG_STATUS,  1, 1, 32'h80000001);
      vecs[10] = mk("w1c_ch1",     8'h00, 1, REG_PENDING, 32'h02,       0, 0, REG_PENDING, 0, 0, 32'h00);
      vecs[11] = mk("mode_write",  8'h00, 1, REG_MODE,    32'h01,       0, 0, REG_MODE,    0, 0, MODE_EXP);
      vecs[12] = mk("status_ro",   8'h00, 1, REG_STATUS,  32'hFFFFFFFF, 0, 0, REG_ENABLE,  0, 0, 32'h02);
      vecs[13] = mk("high_bits",   8'h00, 1, REG_ENABLE,  32'hFFFFFFFF, 0, 0, REG_ENABLE,  0, 0, 32'hFF);
      vecs[14] = mk("ch3_masked",  8'h08, 1, REG_ENABLE,  32'h00,       0, 0, REG_PENDING, 0, 0, 32'h08);
      vecs[15] = mk("ack_idle",    8'h00, 0, REG_ENABLE,  0,            1, 3, REG_PENDING, 0, 0, 32'h00);
      vecs[16] = mk("ch4_edge",    8'h10, 1, REG_ENABLE,  32'hFF,       0, 0, REG_PENDING, 1, 4, 32'h10);
      vecs[17] = mk("ch4_disable", 8'h00, 1, REG_ENABLE,  32'h00,       0, 0, REG_PENDING, 0, 0, 32'h10);
      vecs[18] = mk("ch4_reenab",  8'h00, 1, REG_ENABLE,  32'h10,       0, 0, REG_STATUS,  1, 4, 32'h80000004);
      vecs[19] = mk("ack4",        8'h00, 0, REG_ENABLE,  0,            1, 4, REG_PENDING, 0, 0, 32'h00);
      vecs[20] = mk("enable_back", 8'h00, 1, REG_ENABLE,  32'hFF,       0, 0, REG_ENABLE,  0, 0, 32'hFF);

      // Reset state, sampled while reset is held and again just after release.
      step(3);
      checkOutput("rst_irq", 32'(bus.irq), 0);
      checkOutput("rst_id", 32'(bus.irq_id), 0);
      checkOutput("rst_regq", bus.reg_q, 0);
      nreset = 1'b1;
      bus.reg_addr = REG_ENABLE;  step(1);
      checkOutput("rst_enable", bus.reg_q, 0);
      bus.reg_addr = REG_PENDING; step(1);
      checkOutput("rst_pending", bus.reg_q, 0);
      bus.reg_addr = REG_MODE;    step(1);
      checkOutput("rst_mode", bus.reg_q, 0);

      for (int i = 0; i < 21; i++) applyStimulus(vecs[i]);

      // Cycle-exact event latency on channel 5, then ack latency.
      bus.reg_addr = REG_PENDING;
      irqIn = 8'h20;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         checkOutput($sformatf("lat_irq_%0d", i), 32'(bus.irq), (i == 4) ? 32'd1 : 32'd0);
         checkOutput($sformatf("lat_id_%0d", i), 32'(bus.irq_id), (i == 4) ? 32'd5 : 32'd0);
         checkOutput($sformatf("lat_pend_%0d", i), bus.reg_q, (i == 4) ? 32'h20 : 32'h0);
         if (i == 3) irqIn = 8'h00;
      end
      ackPulse(3'd5);
      checkOutput("ack_hold_irq", 32'(bus.irq), 1);
      checkOutput("ack_hold_pend", bus.reg_q, 32'h20);
      step(1);
      checkOutput("ack_drop_irq", 32'(bus.irq), 0);
      checkOutput("ack_drop_pend", bus.reg_q, 32'h0);

      // New edge on channel 3 lands on the same edge as the ack clearing the old one.
      irqIn = 8'h08;
      step(6);
      checkOutput("coinc_pre_irq", 32'(bus.irq), 1);
      checkOutput("coinc_pre_id", 32'(bus.irq_id), 3);
      irqIn = 8'h00;
      step(4);
      irqIn = 8'h08;
      step(2);
      ackPulse(3'd3);
      for (int i = 0; i < 3; i++) begin
         step(1);
         checkOutput($sformatf("coinc_irq_%0d", i), 32'(bus.irq), 1);
         checkOutput($sformatf("coinc_id_%0d", i), 32'(bus.irq_id), 3);
      end
      checkOutput("coinc_pend", bus.reg_q, 32'h08);
      irqIn = 8'h00;
      ackPulse(3'd3);
      step(2);
      checkOutput("coinc_clear_irq", 32'(bus.irq), 0);

`ifdef IRQ_AGGREGATOR_LEVEL_MODE_EN
      // Level-sensitive channel 0 ignores ack while its source stays high.
      regWrite(REG_MODE, 32'h01);
      regWrite(REG_ENABLE, 32'h01);
      irqIn = 8'h01;
      step(6);
      checkOutput("lvl_irq", 32'(bus.irq), 1);
      ackPulse(3'd0);
      step(1);
      checkOutput("lvl_ack_irq_a", 32'(bus.irq), 1);
      step(1);
      checkOutput("lvl_ack_irq_b", 32'(bus.irq), 1);
      irqIn = 8'h00;
      step(4);
      checkOutput("lvl_low_irq", 32'(bus.irq), 0);
      regWrite(REG_MODE, 32'h00);
      regWrite(REG_ENABLE, 32'hFF);
      step(2);
`endif

      // Source held high across reset release gives exactly one event.
      irqIn = 8'h01;
      #2 nreset = 1'b0;
      step(2);
      nreset = 1'b1;
      regWrite(REG_ENABLE, 32'h01);
      step(5);
      checkOutput("hold_irq", 32'(bus.irq), 1);
      checkOutput("hold_id", 32'(bus.irq_id), 0);
      bus.reg_addr = REG_PENDING; step(1);
      checkOutput("hold_pend", bus.reg_q, 32'h01);
      ackPulse(3'd0);
      step(6);
      checkOutput("hold_once_irq", 32'(bus.irq), 0);
      checkOutput("hold_once_pend", bus.reg_q, 32'h0);

      // Reset asserted mid-event wipes pending and restores enable.
      irqIn = 8'h00;
      step(3);
      irqIn = 8'h01;
      step(6);
      checkOutput("mid_pre_irq", 32'(bus.irq), 1);
      #2 nreset = 1'b0;
      #1;
      checkOutput("mid_irq", 32'(bus.irq), 0);
      checkOutput("mid_regq", bus.reg_q, 0);
      irqIn = 8'h00;
      step(1);
      nreset = 1'b1;
      bus.reg_addr = REG_ENABLE;  step(1);
      checkOutput("mid_enable", bus.reg_q, 0);
      bus.reg_addr = REG_PENDING; step(1);
      checkOutput("mid_pending", bus.reg_q, 0);
      checkOutput("mid_post_irq", 32'(bus.irq), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
